// File: rtl/video_pkg.sv
// Shared types and sizing helpers for the video position tracker and its axis counters.
package video_pkg;

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    TRACK      = 1'b1
  } track_state_t;

  function automatic int section_width(input int resolution, input int sections);
    return resolution / sections;
  endfunction

  // An index for a single item still needs one bit to exist as a port.
  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_pos_tracker_if.sv
// Passive view of one video stream beat: handshake plus its sync/DE sideband.
interface video_pos_tracker_if;
  logic valid_i;
  logic ready_i;
  logic hsync_i;
  logic vsync_i;
  logic vde_i;

  modport master (output valid_i, ready_i, hsync_i, vsync_i, vde_i);
  modport slave  (input  valid_i, ready_i, hsync_i, vsync_i, vde_i);
endinterface

// File: rtl/video_axis_counter.sv
// Saturating position counter for one screen axis, with section index and a
// pulse whenever the last position of a section is passed.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int MAX_COUNT    = 20,
  parameter int NUM_SECTIONS = 4,
  localparam int CW = $clog2(MAX_COUNT + 1),
  localparam int SB = index_bits(NUM_SECTIONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [SB-1:0] sec,
  output logic          edge_pulse,
  output logic          overflow
);

  localparam int SW = section_width(MAX_COUNT, NUM_SECTIONS);
  localparam int PW = index_bits(SW);

  logic [PW-1:0] pos_q;
  logic          advance;
  logic          section_end;

  assign advance     = step && (count != CW'(MAX_COUNT));
  assign overflow    = step && (count == CW'(MAX_COUNT));
  assign section_end = (pos_q == PW'(SW - 1));

  // A clear on the same beat as a step still reports the crossed edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      pos_q      <= '0;
      sec        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= advance && section_end;
      if (clear) begin
        count <= '0;
        pos_q <= '0;
        sec   <= '0;
      end else if (advance) begin
        count <= count + 1'b1;
        if (section_end) begin
          pos_q <= '0;
          sec   <= (sec == SB'(NUM_SECTIONS - 1)) ? '0 : sec + 1'b1;
        end else begin
          pos_q <= pos_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/video_pos_tracker.sv
// Passive monitor that follows the raster position of a video stream and flags
// malformed lines and frames.
module video_pos_tracker
  import video_pkg::*;
#(
  parameter int X_RESOLUTION   = 20,
  parameter int Y_RESOLUTION   = 8,
  parameter int X_NUM_SECTIONS = 4,
  parameter int Y_NUM_SECTIONS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  video_pos_tracker_if.slave                      stream,
  input  logic                                    clr_i,
  output logic [$clog2(X_RESOLUTION+1)-1:0]       x_o,
  output logic [$clog2(Y_RESOLUTION+1)-1:0]       y_o,
  output logic [index_bits(X_NUM_SECTIONS)-1:0]   x_sec_o,
  output logic [index_bits(Y_NUM_SECTIONS)-1:0]   y_sec_o,
  output logic                                    x_edge_o,
  output logic                                    y_edge_o,
  output logic                                    frame_start_o,
  output logic                                    line_err_o,
  output logic                                    frame_err_o,
  output logic                                    in_frame_o,
  output logic                                    err_sticky_o
);

  localparam int XW = $clog2(X_RESOLUTION + 1);
  localparam int YW = $clog2(Y_RESOLUTION + 1);

  if (X_RESOLUTION % X_NUM_SECTIONS != 0) begin : g_bad_x_sections
    $error("X_RESOLUTION must be divisible by X_NUM_SECTIONS");
  end
  if (Y_RESOLUTION % Y_NUM_SECTIONS != 0) begin : g_bad_y_sections
    $error("Y_RESOLUTION must be divisible by Y_NUM_SECTIONS");
  end

  track_state_t state_q, state_d;
  logic prev_hsync_q, prev_vsync_q;
  logic frame_start_q, line_err_q, frame_err_q, err_sticky_q, in_frame_q;

  logic beat, tracking, hsync_rise, vsync_rise;
  logic x_step, x_clear, x_overflow;
  logic y_step, y_clear, y_overflow;
  logic line_done, line_err_d, frame_err_d, err_set;
  logic [YW-1:0] y_after;

  assign beat       = stream.valid_i && stream.ready_i;
  assign tracking   = (state_q == TRACK);
  assign hsync_rise = stream.hsync_i && !prev_hsync_q;
  assign vsync_rise = stream.vsync_i && !prev_vsync_q;

  assign x_clear   = beat && tracking && stream.hsync_i;
  assign x_step    = beat && tracking && stream.vde_i && !stream.hsync_i;
  assign line_done = beat && tracking && hsync_rise && (x_o != '0);
  assign y_step    = line_done;
  assign y_clear   = beat && tracking && vsync_rise;

  video_axis_counter #(
    .MAX_COUNT    (X_RESOLUTION),
    .NUM_SECTIONS (X_NUM_SECTIONS)
  ) u_x_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (x_clear),
    .step       (x_step),
    .count      (x_o),
    .sec        (x_sec_o),
    .edge_pulse (x_edge_o),
    .overflow   (x_overflow)
  );

  video_axis_counter #(
    .MAX_COUNT    (Y_RESOLUTION),
    .NUM_SECTIONS (Y_NUM_SECTIONS)
  ) u_y_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (y_clear),
    .step       (y_step),
    .count      (y_o),
    .sec        (y_sec_o),
    .edge_pulse (y_edge_o),
    .overflow   (y_overflow)
  );

  // Frame length is judged on the line count including a line closed on the same beat.
  always_comb begin
    y_after = y_o;
    if (y_step && (y_o != YW'(Y_RESOLUTION))) begin
      y_after = y_o + 1'b1;
    end
  end

  assign line_err_d  = x_overflow || (line_done && (x_o != XW'(X_RESOLUTION)));
  assign frame_err_d = y_clear && (y_after != YW'(Y_RESOLUTION)) && (y_after != '0);
  assign err_set     = line_err_d || frame_err_d || y_overflow;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VSYNC: if (beat && stream.vsync_i) state_d = TRACK;
      TRACK:      state_d = TRACK;
      default:    state_d = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_VSYNC;
      in_frame_q    <= 1'b0;
      prev_hsync_q  <= 1'b0;
      prev_vsync_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_frame_q    <= (state_d == TRACK);
      frame_start_q <= beat && vsync_rise;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      if (beat) begin
        prev_hsync_q <= stream.hsync_i;
        prev_vsync_q <= stream.vsync_i;
      end
      if (err_set) begin
        err_sticky_q <= 1'b1;
      end else if (clr_i) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign frame_start_o = frame_start_q;
  assign line_err_o    = line_err_q;
  assign frame_err_o   = frame_err_q;
  assign in_frame_o    = in_frame_q;
  assign err_sticky_o  = err_sticky_q;

endmodule

// File: tb/tb_video_pos_tracker.sv
// Directed and randomized beats checked every cycle against a raster-position
// model derived from pixel/line arithmetic.
module tb_video_pos_tracker;

  localparam int XRES = 20;
  localparam int YRES = 8;
  localparam int XN   = 4;
  localparam int YN   = 2;
  localparam int SW   = XRES / XN;
  localparam int SH   = YRES / YN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic [4:0] x_o;
  logic [3:0] y_o;
  logic [1:0] x_sec_o;
  logic [0:0] y_sec_o;
  logic x_edge_o, y_edge_o, frame_start_o, line_err_o, frame_err_o, in_frame_o, err_sticky_o;

  int total = 0;
  int bad = 0;

  // reference model state
  bit m_track, m_prev_hs, m_prev_vs, m_sticky;
  int m_x, m_y;
  bit e_xedge, e_yedge, e_fs, e_lerr, e_ferr;
  int n_xedge, n_yedge, n_fs, n_lerr;

  video_pos_tracker_if vif ();

  video_pos_tracker #(
    .X_RESOLUTION   (XRES),
    .Y_RESOLUTION   (YRES),
    .X_NUM_SECTIONS (XN),
    .Y_NUM_SECTIONS (YN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stream        (vif),
    .clr_i         (clr),
    .x_o           (x_o),
    .y_o           (y_o),
    .x_sec_o       (x_sec_o),
    .y_sec_o       (y_sec_o),
    .x_edge_o      (x_edge_o),
    .y_edge_o      (y_edge_o),
    .frame_start_o (frame_start_o),
    .line_err_o    (line_err_o),
    .frame_err_o   (frame_err_o),
    .in_frame_o    (in_frame_o),
    .err_sticky_o  (err_sticky_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ":in_frame"}, 8'(in_frame_o), 8'(m_track));
    check_val({tag, ":x"}, 8'(x_o), 8'(m_x));
    check_val({tag, ":y"}, 8'(y_o), 8'(m_y));
    check_val({tag, ":x_sec"}, 8'(x_sec_o), 8'((m_x / SW) % XN));
    check_val({tag, ":y_sec"}, 8'(y_sec_o), 8'((m_y / SH) % YN));
    check_val({tag, ":x_edge"}, 8'(x_edge_o), 8'(e_xedge));
    check_val({tag, ":y_edge"}, 8'(y_edge_o), 8'(e_yedge));
    check_val({tag, ":frame_start"}, 8'(frame_start_o), 8'(e_fs));
    check_val({tag, ":line_err"}, 8'(line_err_o), 8'(e_lerr));
    check_val({tag, ":frame_err"}, 8'(frame_err_o), 8'(e_ferr));
    check_val({tag, ":sticky"}, 8'(err_sticky_o), 8'(m_sticky));
    n_xedge += int'(x_edge_o === 1'b1);
    n_yedge += int'(y_edge_o === 1'b1);
    n_fs    += int'(frame_start_o === 1'b1);
    n_lerr  += int'(line_err_o === 1'b1);
  endtask

  task automatic model_reset();
    m_track = 0; m_prev_hs = 0; m_prev_vs = 0; m_sticky = 0;
    m_x = 0; m_y = 0;
    e_xedge = 0; e_yedge = 0; e_fs = 0; e_lerr = 0; e_ferr = 0;
  endtask

  // Position rules: pixels counted per line, lines per frame, both saturating.
  task automatic model_step(input bit beat, input bit hs, input bit vs, input bit vde, input bit c);
    bit extra_line;
    extra_line = 0;
    e_xedge = 0; e_yedge = 0; e_fs = 0; e_lerr = 0; e_ferr = 0;
    if (beat) begin
      e_fs = vs && !m_prev_vs;
      if (!m_track) begin
        m_track = vs;
      end else begin
        if (hs) begin
          if (!m_prev_hs && m_x != 0) begin
            e_lerr = (m_x != XRES);
            if (m_y == YRES) extra_line = 1;
            else begin
              m_y++;
              e_yedge = (m_y % SH == 0);
            end
          end
          m_x = 0;
        end else if (vde) begin
          if (m_x == XRES) e_lerr = 1;
          else begin
            m_x++;
            e_xedge = (m_x % SW == 0);
          end
        end
        if (vs && !m_prev_vs) begin
          e_ferr = (m_y != YRES) && (m_y != 0);
          m_y = 0;
        end
      end
      m_prev_hs = hs;
      m_prev_vs = vs;
    end
    if (e_lerr || e_ferr || extra_line) m_sticky = 1;
    else if (c) m_sticky = 0;
  endtask

  task automatic apply_stimulus(input bit valid, input bit ready, input bit hs, input bit vs,
                                input bit vde, input string tag);
    vif.valid_i = valid;
    vif.ready_i = ready;
    vif.hsync_i = hs;
    vif.vsync_i = vs;
    vif.vde_i   = vde;
    @(posedge clk);
    model_step(valid && ready, hs, vs, vde, clr);
    #1;
    check_output(tag);
  endtask

  task automatic gap(input int n);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = 1'($urandom);
      apply_stimulus(v, v ? 1'b0 : 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "gap");
    end
  endtask

  task automatic pixels(input int n, input int gmin, input int gmax, input string tag);
    for (int i = 0; i < n; i++) begin
      gap($urandom_range(gmax, gmin));
      apply_stimulus(1, 1, 0, 0, 1, tag);
    end
  endtask

  task automatic clear_sticky();
    clr = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, "clr");
    clr = 1'b0;
  endtask

  initial begin
    vif.valid_i = 0; vif.ready_i = 0; vif.hsync_i = 0; vif.vsync_i = 0; vif.vde_i = 0;
    model_reset();
    n_xedge = 0; n_yedge = 0; n_fs = 0; n_lerr = 0;
    #3;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] data without vsync stays idle");
    n_xedge = 0;
    pixels(30, 0, 2, "no_vsync");
    check_val("no_vsync_edges", 8'(n_xedge), 8'd0);

    $display("[TB] first line with 1-10 cycle gaps");
    apply_stimulus(1, 1, 0, 1, 0, "vsync0");
    apply_stimulus(1, 1, 1, 0, 0, "hsync0");
    n_xedge = 0;
    pixels(XRES, 1, 10, "line0");
    check_val("line0_edges", 8'(n_xedge), 8'd4);

    $display("[TB] full frame then vsync");
    n_yedge = 0;
    apply_stimulus(1, 1, 1, 0, 0, "hsync_end0");
    for (int l = 1; l < YRES; l++) begin
      pixels(XRES, 0, 2, "frame");
      apply_stimulus(1, 1, 1, 0, 0, "hsync_end");
    end
    n_fs = 0;
    apply_stimulus(1, 1, 0, 1, 0, "vsync1");
    check_val("frame_y_edges", 8'(n_yedge), 8'd2);
    check_val("frame_starts", 8'(n_fs), 8'd1);

    $display("[TB] short line");
    apply_stimulus(1, 1, 1, 0, 0, "hsync_empty");
    pixels(XRES - 1, 0, 2, "short");
    n_lerr = 0;
    apply_stimulus(1, 1, 1, 0, 0, "hsync_short");
    gap(5);
    check_val("short_line_errs", 8'(n_lerr), 8'd1);
    clear_sticky();

    $display("[TB] stall and overlong line");
    pixels(3, 0, 1, "pre_stall");
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 0, 1, "stall");
    pixels(XRES - 3, 0, 1, "post_stall");
    apply_stimulus(1, 1, 0, 0, 1, "overflow");
    apply_stimulus(1, 1, 1, 0, 0, "hsync_full");
    clear_sticky();

    $display("[TB] hsync and vsync on the same beat");
    pixels(XRES, 0, 1, "pre_both");
    apply_stimulus(1, 1, 1, 1, 0, "both");
    clear_sticky();

    $display("[TB] reset mid-line");
    apply_stimulus(1, 1, 1, 0, 0, "hsync_pre_rst");
    pixels(7, 0, 1, "pre_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("mid_reset");
    @(posedge clk);
    #1;
    check_output("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 1, 0, 1, 0, "vsync_after_rst");
    apply_stimulus(1, 1, 1, 0, 0, "hsync_after_rst");
    pixels(XRES, 0, 2, "line_after_rst");
    apply_stimulus(1, 1, 1, 0, 0, "hsync_line_after_rst");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(29, 0) == 0);
      apply_stimulus(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
                     ($urandom_range(23, 0) == 0), ($urandom_range(149, 0) == 0),
                     ($urandom_range(3, 0) != 0), "random");
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pos_tracker.md
VIDEO_POS_TRACKER -- requirements
Module: video_pos_tracker

Interface
REQ-001 SHALL have parameter X_RESOLUTION, default 20, meaning active pixels per line.
REQ-002 SHALL have parameter Y_RESOLUTION, default 8, meaning active lines per frame.
REQ-003 SHALL have parameter X_NUM_SECTIONS, default 4, meaning horizontal sections; X_RESOLUTION divisible by it, elaboration error otherwise.
REQ-004 SHALL have parameter Y_NUM_SECTIONS, default 2, meaning vertical sections; Y_RESOLUTION divisible by it, elaboration error otherwise.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: valid_i  in  1  stream valid; ready_i  in  1  stream ready (passive monitor, drives neither).
REQ-007 SHALL have ports: hsync_i, vsync_i, vde_i  in  1 each  sideband of current beat.
REQ-008 SHALL have ports: clr_i  in  1  clears sticky error.
REQ-009 SHALL have ports: x_o  out  $clog2(X_RESOLUTION+1)  next pixel index; y_o  out  $clog2(Y_RESOLUTION+1)  current line index.
REQ-010 SHALL have ports: x_sec_o, y_sec_o  out  $clog2(N_SECTIONS) (min 1)  current section index.
REQ-011 SHALL have ports: x_edge_o, y_edge_o, frame_start_o, line_err_o, frame_err_o  out  1  single-cycle pulses.
REQ-012 SHALL have ports: in_frame_o  out  1  FSM in TRACK; err_sticky_o  out  1  sticky error.

Function
REQ-013 SHALL advance state only on beat = valid_i & ready_i; no beat, no change; pulses low.
REQ-014 SHALL implement FSM WAIT_VSYNC -> TRACK on first beat with vsync_i=1; TRACK never returns except by reset.
REQ-015 SHALL in WAIT_VSYNC hold counters 0 and emit no edge or error pulses.
REQ-016 SHALL pulse frame_start_o the cycle after a beat with vsync_i=1 whose previous beat had vsync_i=0 (first vsync included).
REQ-017 SHALL on a beat with hsync_i=1 clear x_o and x_sec_o; on beat with vde_i=1, hsync_i=0 increment x_o.
REQ-018 SHALL pulse x_edge_o the cycle after the beat of pixel index k*SW-1 (SW = X_RESOLUTION/X_NUM_SECTIONS, k=1..X_NUM_SECTIONS); x_sec_o increments with it, wrapping to 0 after the last section.
REQ-019 SHALL saturate x_o at X_RESOLUTION; an active beat at saturation sets err_sticky_o and pulses line_err_o.
REQ-020 SHALL on hsync rising (hsync_i=1 beat, prior beat hsync_i=0) with line pixel count nonzero: increment y_o; pulse line_err_o if count != X_RESOLUTION.
REQ-021 SHALL pulse y_edge_o on that increment when the completed line is index k*SH-1 (SH = Y_RESOLUTION/Y_NUM_SECTIONS); y_sec_o advances, wraps to 0.
REQ-022 SHALL on vsync rising in TRACK pulse frame_err_o if y_o != Y_RESOLUTION and y_o != 0, then clear y_o, y_sec_o.
REQ-023 SHALL saturate y_o at Y_RESOLUTION; a further counted line sets err_sticky_o.
REQ-024 SHALL set err_sticky_o on any line_err_o/frame_err_o; clr_i clears it; simultaneous set and clr_i -> set wins.
REQ-025 SHALL with vsync_i and hsync_i on same beat apply vsync clear after hsync processing (y_o ends 0).
REQ-026 SHALL register all outputs; latency one cycle from beat.

Reset
REQ-027 SHALL on rst_n low drive every output 0 and FSM to WAIT_VSYNC, regardless of line position.
REQ-028 SHALL reset the stored previous hsync/vsync beat values to 0.

Structure
REQ-029 SHALL place FSM state typedef and section-width helper function in shared package video_pkg.
REQ-030 SHALL use one sub-module, video_axis_counter (count, saturate, section index, edge pulse), instantiated for x and y.

Verification
REQ-031 SHALL cover: reset, 30 vde beats without vsync -> in_frame_o=0, no x_edge_o, x_o=0.
REQ-032 SHALL cover: vsync, hsync, 20 vde beats with 1-10 cycle gaps -> x_edge_o after pixels 4,9,14,19; x_sec_o 0,1,2,3,0.
REQ-033 SHALL cover: 8 full lines then vsync -> y_edge_o after lines 3 and 7, frame_err_o=0, frame_start_o once.
REQ-034 SHALL cover: line of 19 pixels then hsync -> line_err_o one pulse, err_sticky_o=1 until clr_i.
REQ-035 SHALL cover: valid_i=1, ready_i=0 for 10 cycles with vde_i=1 -> x_o unchanged.
REQ-036 SHALL cover: rst_n low mid-line at x_o=7 -> all outputs 0, WAIT_VSYNC, next frame tracked correctly.
